tx_symbol_scheduler: RTL and testbench

- Transmit-side 8b/10b controller. Sequences the encoder_5b6b and encoder_3b4b sub-block encoders and owns the running-disparity (RD) register.
- Arbitrates each symbol slot between upstream byte data, logical idle and periodic SKP ordered sets.
- Sits between the link-layer byte stream and the serializer, and emits one registered 10-bit symbol per clock.

---
 rtl/tx_symbol_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_tx_symbol_scheduler.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/tx_symbol_scheduler.sv
// 8b/10b transmit symbol scheduler: byte/idle/SKP slot arbitration, 5b6b+3b4b encode, running disparity.
// Optional SKP ordered-set insertion is compiled in with `define TX_SKP_INSERT_EN.
module tx_symbol_scheduler #(
    parameter int unsigned SKP_INTERVAL = 1180,
    parameter int unsigned SKP_COUNT    = 3
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] data_i,
    input  logic       is_k_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic [9:0] symbol_o,
    output logic       symbol_valid_o,
    output logic       rd_n_o,
    output logic       k_err_o
);
    localparam int unsigned CNT_W = 12;
    localparam int unsigned SUB_W = 3;

    if (SKP_INTERVAL < 8 || SKP_INTERVAL > 4095 || SKP_COUNT < 1 || SKP_COUNT > 5) begin : g_bad_cfg
        $error("tx_symbol_scheduler: SKP_INTERVAL or SKP_COUNT out of range");
    end

    typedef enum logic [1:0] {ST_START, ST_DATA, ST_SKP_COM, ST_SKP_SYM} state_t;

    state_t     r_state, w_state_nxt;
    logic [9:0] r_symbol;
    logic       r_sym_valid, r_rd_n, r_k_err;
    logic       w_skp_due, w_emit, w_sel_k28, w_accept, w_k_legal, w_k_err, w_k;
    logic [2:0] w_sel_y;
    logic [7:0] w_byte;
    logic [4:0] w_x;
    logic [2:0] w_y;
    logic [5:0] w_6b_base, w_6b;
    logic [3:0] w_4b_base, w_4b;
    logic       w_rd_mid_n, w_rd_out_n, w_a7;

    // abcdei for RD- start
    function automatic logic [5:0] enc6(input logic [4:0] x);
        case (x)
            5'd0:  enc6 = 6'b100111;  5'd1:  enc6 = 6'b011101;
            5'd2:  enc6 = 6'b101101;  5'd3:  enc6 = 6'b110001;
            5'd4:  enc6 = 6'b110101;  5'd5:  enc6 = 6'b101001;
            5'd6:  enc6 = 6'b011001;  5'd7:  enc6 = 6'b111000;
            5'd8:  enc6 = 6'b111001;  5'd9:  enc6 = 6'b100101;
            5'd10: enc6 = 6'b010101;  5'd11: enc6 = 6'b110100;
            5'd12: enc6 = 6'b001101;  5'd13: enc6 = 6'b101100;
            5'd14: enc6 = 6'b011100;  5'd15: enc6 = 6'b010111;
            5'd16: enc6 = 6'b011011;  5'd17: enc6 = 6'b100011;
            5'd18: enc6 = 6'b010011;  5'd19: enc6 = 6'b110010;
            5'd20: enc6 = 6'b001011;  5'd21: enc6 = 6'b101010;
            5'd22: enc6 = 6'b011010;  5'd23: enc6 = 6'b111010;
            5'd24: enc6 = 6'b110011;  5'd25: enc6 = 6'b100110;
            5'd26: enc6 = 6'b010110;  5'd27: enc6 = 6'b110110;
            5'd28: enc6 = 6'b001110;  5'd29: enc6 = 6'b101110;
            5'd30: enc6 = 6'b011110;  default: enc6 = 6'b101011;
        endcase
    endfunction

    // fghj for rd_mid negative; data and control tables differ on the balanced codes
    function automatic logic [3:0] enc4(input logic [2:0] y, input logic k);
        case (y)
            3'd0: enc4 = 4'b1011;
            3'd1: enc4 = k ? 4'b0110 : 4'b1001;
            3'd2: enc4 = k ? 4'b1010 : 4'b0101;
            3'd3: enc4 = 4'b1100;
            3'd4: enc4 = 4'b1101;
            3'd5: enc4 = k ? 4'b0101 : 4'b1010;
            3'd6: enc4 = k ? 4'b1001 : 4'b0110;
            default: enc4 = 4'b1110;
        endcase
    endfunction

`ifdef TX_SKP_INSERT_EN
    logic [CNT_W-1:0] r_skp_cnt;
    logic [SUB_W-1:0] r_sub;

    assign w_skp_due = (r_state == ST_DATA) && (r_skp_cnt == CNT_W'(SKP_INTERVAL - 1));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_skp_cnt <= '0;
            r_sub     <= '0;
        end else begin
            if (r_state == ST_DATA && !w_skp_due)
                r_skp_cnt <= r_skp_cnt + CNT_W'(1);
            else if (r_state == ST_SKP_COM)
                r_skp_cnt <= '0;
            if (r_state == ST_SKP_COM)
                r_sub <= SUB_W'(SKP_COUNT - 1);
            else if (r_state == ST_SKP_SYM && r_sub != '0)
                r_sub <= r_sub - SUB_W'(1);
        end
    end
`else
    assign w_skp_due = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) r_state <= ST_START;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_START: w_state_nxt = ST_DATA;
`ifdef TX_SKP_INSERT_EN
            ST_DATA:    if (w_skp_due) w_state_nxt = ST_SKP_COM;
            ST_SKP_COM: w_state_nxt = ST_SKP_SYM;
            ST_SKP_SYM: if (r_sub == '0) w_state_nxt = ST_DATA;
`endif
            default: ;
        endcase
    end

    always_comb begin
        ready_o   = 1'b0;
        w_sel_k28 = 1'b0;
        w_sel_y   = 3'd0;
        w_emit    = (r_state != ST_START);
        case (r_state)
            ST_DATA:    ready_o = !w_skp_due;
            ST_SKP_COM: begin w_sel_k28 = 1'b1; w_sel_y = 3'd5; end
            ST_SKP_SYM: w_sel_k28 = 1'b1;
            default: ;
        endcase
    end

    // Slot source: ordered-set symbol, accepted byte, or D0.0 idle
    assign w_accept  = ready_o & valid_i;
    assign w_k_legal = (data_i[4:0] == 5'd28) ||
                       (data_i[7:5] == 3'd7 && (data_i[4:0] == 5'd23 || data_i[4:0] == 5'd27 ||
                                                data_i[4:0] == 5'd29 || data_i[4:0] == 5'd30));
    assign w_k_err   = w_accept & is_k_i & ~w_k_legal;

    always_comb begin
        w_byte = 8'h00;
        w_k    = 1'b0;
        if (w_sel_k28) begin
            w_byte = {w_sel_y, 5'd28};
            w_k    = 1'b1;
        end else if (w_accept) begin
            w_byte = data_i;
            w_k    = is_k_i & w_k_legal;
        end
    end

    assign w_x = w_byte[4:0];
    assign w_y = w_byte[7:5];

    always_comb begin
        w_6b_base = enc6(w_x);
        if (w_k && w_x == 5'd28)
            w_6b = r_rd_n ? 6'b001111 : 6'b110000;
        else if (!r_rd_n && (($countones(w_6b_base) != 3) || w_x == 5'd7))
            w_6b = ~w_6b_base;
        else
            w_6b = w_6b_base;
        w_rd_mid_n = ($countones(w_6b) != 3) ? ~r_rd_n : r_rd_n;

        w_a7 = w_k || (w_rd_mid_n  && (w_x == 5'd17 || w_x == 5'd18 || w_x == 5'd20)) ||
                      (!w_rd_mid_n && (w_x == 5'd11 || w_x == 5'd13 || w_x == 5'd14));
        w_4b_base = (w_y == 3'd7 && w_a7) ? 4'b0111 : enc4(w_y, w_k);
        if (!w_rd_mid_n && (w_k || w_y == 3'd0 || w_y == 3'd3 || w_y == 3'd4 || w_y == 3'd7))
            w_4b = ~w_4b_base;
        else
            w_4b = w_4b_base;
        w_rd_out_n = ($countones(w_4b) != 2) ? ~w_rd_mid_n : w_rd_mid_n;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_symbol    <= '0;
            r_sym_valid <= 1'b0;
            r_rd_n      <= 1'b1;
            r_k_err     <= 1'b0;
        end else if (w_emit) begin
            r_symbol    <= {w_6b, w_4b};
            r_sym_valid <= 1'b1;
            r_rd_n      <= w_rd_out_n;
            r_k_err     <= w_k_err;
        end
    end

    assign symbol_o       = r_symbol;
    assign symbol_valid_o = r_sym_valid;
    assign rd_n_o         = r_rd_n;
    assign k_err_o        = r_k_err;
endmodule

// File: tb/tb_tx_symbol_scheduler.sv
// Bench for tx_symbol_scheduler: directed vector table plus reset and SKP ordered-set sequences.
// SKP sequences run only when TX_SKP_INSERT_EN is defined.
module tb_tx_symbol_scheduler;
    logic       clk = 1'b0;
    logic       reset_i, is_k_i, valid_i;
    logic [7:0] data_i;
    logic       ready_o, symbol_valid_o, rd_n_o, k_err_o;
    logic [9:0] symbol_o;
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    tx_symbol_scheduler u_dut (
        .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .is_k_i(is_k_i), .valid_i(valid_i),
        .ready_o(ready_o), .symbol_o(symbol_o), .symbol_valid_o(symbol_valid_o),
        .rd_n_o(rd_n_o), .k_err_o(k_err_o)
    );

    typedef struct {
        logic [7:0] data;
        logic       k;
        logic       v;
        logic [9:0] sym;
        logic       rd_n;
        logic       kerr;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " sym"},   symbol_o, 10'd0);
        check({tag, " valid"}, 10'(symbol_valid_o), 10'd0);
        check({tag, " rd_n"},  10'(rd_n_o), 10'd1);
        check({tag, " kerr"},  10'(k_err_o), 10'd0);
        check({tag, " ready"}, 10'(ready_o), 10'd0);
    endtask

`ifdef TX_SKP_INSERT_EN
    logic       s_rst, s_valid, s_ready, s_sym_valid, s_rd_n, s_kerr;
    logic [7:0] s_data;
    logic [9:0] s_sym;

    tx_symbol_scheduler #(.SKP_INTERVAL(8), .SKP_COUNT(3)) u_skp (
        .clk_i(clk), .reset_i(s_rst), .data_i(s_data), .is_k_i(1'b0), .valid_i(s_valid),
        .ready_o(s_ready), .symbol_o(s_sym), .symbol_valid_o(s_sym_valid),
        .rd_n_o(s_rd_n), .k_err_o(s_kerr)
    );

    typedef struct {
        logic       rdy;
        logic [9:0] sym;
        logic       rd_n;
    } skp_t;

    skp_t skp_exp[23];
    localparam logic [9:0] C_B5   = 10'b101010_1010;
    localparam logic [9:0] C_4A   = 10'b010101_0101;
    localparam logic [9:0] C_SKPP = 10'b110000_1011;
    localparam logic [9:0] C_SKPN = 10'b001111_0100;

    task automatic run_skp();
        int         idx = 0;
        logic       hs;
        logic [7:0] bytes[2];
        bytes[0] = 8'hB5;
        bytes[1] = 8'h4A;
        for (int i = 0; i < 23; i++) begin
            if (i < 7)       skp_exp[i] = '{1'b1, (i % 2 == 0) ? C_B5 : C_4A, 1'b1};
            else if (i < 12) skp_exp[i] = '{1'b0, C_SKPP, 1'b0};
            else if (i < 19) skp_exp[i] = '{1'b1, (i % 2 == 0) ? C_4A : C_B5, 1'b0};
            else             skp_exp[i] = '{1'b0, C_SKPN, 1'b1};
        end
        skp_exp[7]  = '{1'b0, 10'b100111_0100, 1'b1};
        skp_exp[8]  = '{1'b0, 10'b001111_1010, 1'b0};
        skp_exp[19] = '{1'b0, 10'b011000_1011, 1'b0};
        skp_exp[20] = '{1'b0, 10'b110000_0101, 1'b1};

        s_rst = 1'b1; s_valid = 1'b0; s_data = 8'h00;
        repeat (2) @(posedge clk);
        #1 s_rst = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 23; i++) begin
            #1 s_data = bytes[idx % 2]; s_valid = 1'b1;
            #1 check($sformatf("skp%0d ready", i), 10'(s_ready), 10'(skp_exp[i].rdy));
            hs = s_ready;
            @(posedge clk);
            #1 check($sformatf("skp%0d sym", i), s_sym, skp_exp[i].sym);
            check($sformatf("skp%0d rd_n", i), 10'(s_rd_n), 10'(skp_exp[i].rd_n));
            if (hs) idx++;
        end
        // second SKP of the second ordered set is on the line: abandon it
        #2 s_rst = 1'b1;
        #1 check("skp_rst sym", s_sym, 10'd0);
        check("skp_rst valid", 10'(s_sym_valid), 10'd0);
        check("skp_rst rd_n", 10'(s_rd_n), 10'd1);
        check("skp_rst ready", 10'(s_ready), 10'd0);
        @(posedge clk);
        #1 s_rst = 1'b0; s_valid = 1'b0;
        @(posedge clk);
        repeat (3) begin
            @(posedge clk);
            #1 check("skp_post idle", s_sym, 10'b100111_0100);
            check("skp_post rd_n", 10'(s_rd_n), 10'd1);
            check("skp_post ready", 10'(s_ready), 10'd1);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{8'h00, 1'b0, 1'b0, 10'b100111_0100, 1'b1, 1'b0};
        vecs[1]  = '{8'hBC, 1'b1, 1'b1, 10'b001111_1010, 1'b0, 1'b0};
        vecs[2]  = '{8'hBC, 1'b1, 1'b1, 10'b110000_0101, 1'b1, 1'b0};
        vecs[3]  = '{8'hBC, 1'b1, 1'b1, 10'b001111_1010, 1'b0, 1'b0};
        vecs[4]  = '{8'hEB, 1'b0, 1'b1, 10'b110100_1000, 1'b1, 1'b0};
        vecs[5]  = '{8'hB5, 1'b0, 1'b1, 10'b101010_1010, 1'b1, 1'b0};
        vecs[6]  = '{8'h05, 1'b1, 1'b1, 10'b101001_1011, 1'b0, 1'b1};
        vecs[7]  = '{8'h00, 1'b0, 1'b0, 10'b011000_1011, 1'b0, 1'b0};
        vecs[8]  = '{8'hE7, 1'b0, 1'b1, 10'b000111_0001, 1'b1, 1'b0};
        vecs[9]  = '{8'hFC, 1'b1, 1'b1, 10'b001111_1000, 1'b1, 1'b0};
        vecs[10] = '{8'hF7, 1'b1, 1'b1, 10'b111010_1000, 1'b1, 1'b0};
        vecs[11] = '{8'hF1, 1'b0, 1'b1, 10'b100011_0111, 1'b0, 1'b0};
        vecs[12] = '{8'h63, 1'b0, 1'b1, 10'b110001_0011, 1'b0, 1'b0};
        vecs[13] = '{8'h3C, 1'b1, 1'b1, 10'b110000_0110, 1'b1, 1'b0};
        vecs[14] = '{8'h3F, 1'b0, 1'b1, 10'b101011_1001, 1'b0, 1'b0};
        vecs[15] = '{8'hFB, 1'b1, 1'b1, 10'b001001_0111, 1'b0, 1'b0};
        vecs[16] = '{8'h00, 1'b0, 1'b0, 10'b011000_1011, 1'b0, 1'b0};
        vecs[17] = '{8'h00, 1'b1, 1'b1, 10'b011000_1011, 1'b0, 1'b1};
        vecs[18] = '{8'h7E, 1'b1, 1'b1, 10'b100001_1100, 1'b1, 1'b1};

        reset_i = 1'b1; valid_i = 1'b0; is_k_i = 1'b0; data_i = 8'h00;
`ifdef TX_SKP_INSERT_EN
        s_rst = 1'b1; s_valid = 1'b0; s_data = 8'h00;
`endif
        #3 check_reset_vals("reset");
        repeat (2) @(posedge clk);
        #1 reset_i = 1'b0;
        @(posedge clk);
        #1 check("start valid", 10'(symbol_valid_o), 10'd0);
        check("start ready", 10'(ready_o), 10'd1);

        for (int i = 0; i < 19; i++) begin
            data_i = vecs[i].data; is_k_i = vecs[i].k; valid_i = vecs[i].v;
            #1 check($sformatf("v%0d ready", i), 10'(ready_o), 10'd1);
            @(posedge clk);
            #1 check($sformatf("v%0d sym", i), symbol_o, vecs[i].sym);
            check($sformatf("v%0d rd_n", i), 10'(rd_n_o), 10'(vecs[i].rd_n));
            check($sformatf("v%0d kerr", i), 10'(k_err_o), 10'(vecs[i].kerr));
            check($sformatf("v%0d valid", i), 10'(symbol_valid_o), 10'd1);
        end

        // Async reset while RD is positive must restore RD- without a clock edge
        data_i = 8'hBC; is_k_i = 1'b1; valid_i = 1'b1;
        @(posedge clk);
        #1 check("pre_rst sym", symbol_o, 10'b001111_1010);
        check("pre_rst rd_n", 10'(rd_n_o), 10'd0);
        valid_i = 1'b0; is_k_i = 1'b0; data_i = 8'h00;
        #2 reset_i = 1'b1;
        #1 check_reset_vals("async_rst");
        @(posedge clk);
        #1 reset_i = 1'b0;
        @(posedge clk);
        #1 check("rst_start valid", 10'(symbol_valid_o), 10'd0);
        @(posedge clk);
        #1 check("rst_idle sym", symbol_o, 10'b100111_0100);
        check("rst_idle rd_n", 10'(rd_n_o), 10'd1);
        check("rst_idle valid", 10'(symbol_valid_o), 10'd1);

`ifdef TX_SKP_INSERT_EN
        run_skp();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
